// File: rtl/instruction_fetch.sv
// Program counter and instruction register for the multicycle RV32I core.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch #(
    parameter int                  PC_WIDTH       = 10,
    parameter logic [PC_WIDTH-1:0] RESET_PC       = {PC_WIDTH{1'b0}},
    parameter logic [31:0]         NOP_INSN       = 32'h00000013,
    parameter int                  TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pc_wren,
    input  logic [1:0]          pc_mux,
    input  logic [PC_WIDTH-1:0] pc_immediate,
    input  logic [31:0]         alu_result,
    input  logic                ir_wren,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    input  logic                imem_valid,
    output logic [31:0]         instruction,
    output logic [PC_WIDTH-1:0] pc,
    output logic                fetch_busy,
    output logic                fetch_done,
    output logic                pc_misaligned,
    output logic                fetch_fault
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]          state_r;
    logic [PC_WIDTH-1:0] pc_r;
    logic [PC_WIDTH-1:0] imem_addr_r;
    logic [31:0]         instruction_r;
    logic                imem_req_r;
    logic                fetch_busy_r;
    logic                fetch_done_r;
    logic                pc_misaligned_r;
    logic [PC_WIDTH-1:0] pc_target_s;
    logic                fetch_start_s;
    logic                timeout_s;
    logic                unused_alu_s;

    // Upper JALR target bits are beyond the instruction address space.
    assign unused_alu_s = ^{1'b0, alu_result[31:PC_WIDTH]};

    // Next-PC selection; all arithmetic wraps modulo 2^PC_WIDTH.
    always_comb begin
        pc_target_s = RESET_PC;
        case (pc_mux)
            2'd0:    pc_target_s = pc_r + PC_WIDTH'(3'd4);
            2'd1:    pc_target_s = pc_r + pc_immediate;
            2'd2:    pc_target_s = alu_result[PC_WIDTH-1:0];
            2'd3:    pc_target_s = RESET_PC;
            default: pc_target_s = RESET_PC;
        endcase
    end

    // A fetch is accepted from IDLE, or back-to-back from DONE.
    always_comb begin
        if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
            fetch_start_s = ir_wren;
        end else begin
            fetch_start_s = 1'b0;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt_r;
    logic             fetch_fault_r;

    // Watchdog fires on the last allowed REQ cycle when memory stays silent.
    always_comb begin
        if ((state_r == ST_REQ) && !imem_valid && (wait_cnt_r == CNT_LAST)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // REQ-cycle counter, restarted on every accepted fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (fetch_start_s) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_REQ) && (wait_cnt_r != CNT_LAST)) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1'b1);
        end
    end

    // Fault flag is sticky until the next fetch is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_fault_r <= 1'b0;
        end else if (fetch_start_s) begin
            fetch_fault_r <= 1'b0;
        end else if (timeout_s) begin
            fetch_fault_r <= 1'b1;
        end
    end

    assign fetch_fault = fetch_fault_r;
`else
    localparam int unused_timeout_p = TIMEOUT_CYCLES;

    assign timeout_s   = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    // PC register with misalignment reporting; may update in any fetch state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r            <= RESET_PC;
            pc_misaligned_r <= 1'b0;
        end else if (pc_wren) begin
            pc_r            <= {pc_target_s[PC_WIDTH-1:2], 2'b00};
            pc_misaligned_r <= |pc_target_s[1:0];
        end else begin
            pc_misaligned_r <= 1'b0;
        end
    end

    // Fetch FSM: address is captured once per request and held until data returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            imem_req_r    <= 1'b0;
            imem_addr_r   <= {PC_WIDTH{1'b0}};
            instruction_r <= NOP_INSN;
            fetch_busy_r  <= 1'b0;
            fetch_done_r  <= 1'b0;
        end else begin
            fetch_done_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (fetch_start_s) begin
                        state_r      <= ST_REQ;
                        imem_addr_r  <= pc_r;
                        imem_req_r   <= 1'b1;
                        fetch_busy_r <= 1'b1;
                    end else begin
                        state_r      <= ST_IDLE;
                        imem_req_r   <= 1'b0;
                        fetch_busy_r <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (imem_valid) begin
                        instruction_r <= imem_rdata;
                        imem_req_r    <= 1'b0;
                        fetch_busy_r  <= 1'b0;
                        fetch_done_r  <= 1'b1;
                        state_r       <= ST_DONE;
                    end else if (timeout_s) begin
                        instruction_r <= NOP_INSN;
                        imem_req_r    <= 1'b0;
                        fetch_busy_r  <= 1'b0;
                        fetch_done_r  <= 1'b1;
                        state_r       <= ST_DONE;
                    end else begin
                        imem_req_r    <= 1'b1;
                        fetch_busy_r  <= 1'b1;
                        state_r       <= ST_REQ;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    imem_req_r   <= 1'b0;
                    fetch_busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req      = imem_req_r;
    assign imem_addr     = imem_addr_r;
    assign instruction   = instruction_r;
    assign pc            = pc_r;
    assign fetch_busy    = fetch_busy_r;
    assign fetch_done    = fetch_done_r;
    assign pc_misaligned = pc_misaligned_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch; define FETCH_TIMEOUT_EN to cover the watchdog.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        pc_wren;
    logic [1:0]  pc_mux;
    logic [9:0]  pc_immediate;
    logic [31:0] alu_result;
    logic        ir_wren;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] instruction;
    logic [9:0]  pc;
    logic        fetch_busy;
    logic        fetch_done;
    logic        pc_misaligned;
    logic        fetch_fault;

    int vectors    = 0;
    int miscompares = 0;

    instruction_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .pc_wren       (pc_wren),
        .pc_mux        (pc_mux),
        .pc_immediate  (pc_immediate),
        .alu_result    (alu_result),
        .ir_wren       (ir_wren),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .instruction   (instruction),
        .pc            (pc),
        .fetch_busy    (fetch_busy),
        .fetch_done    (fetch_done),
        .pc_misaligned (pc_misaligned),
        .fetch_fault   (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; pc_wren = 1'b0; pc_mux = 2'd0; pc_immediate = 10'h000;
        alu_result = 32'h0; ir_wren = 1'b0; imem_rdata = 32'h0; imem_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_pc", 32'(pc), 32'h000);
        chk("rst_insn", instruction, 32'h00000013);
        chk1("rst_req", imem_req, 1'b0);
        chk("rst_addr", 32'(imem_addr), 32'h000);
        chk1("rst_busy", fetch_busy, 1'b0);
        chk1("rst_done", fetch_done, 1'b0);
        chk1("rst_mis", pc_misaligned, 1'b0);
        chk1("rst_fault", fetch_fault, 1'b0);

        // Basic fetch with data on the first request cycle
        ir_wren = 1'b1;
        tick();
        ir_wren = 1'b0;
        chk1("f1_req", imem_req, 1'b1);
        chk1("f1_busy", fetch_busy, 1'b1);
        chk("f1_addr", 32'(imem_addr), 32'h000);
        chk1("f1_nodone", fetch_done, 1'b0);
        imem_valid = 1'b1; imem_rdata = 32'h00500093;
        tick();
        imem_valid = 1'b0; imem_rdata = 32'h0;
        chk("f1_insn", instruction, 32'h00500093);
        chk1("f1_done", fetch_done, 1'b1);
        chk1("f1_req_off", imem_req, 1'b0);
        tick();
        chk1("f1_done_pulse", fetch_done, 1'b0);
        chk("f1_insn_hold", instruction, 32'h00500093);

        // PC wrap at top of address space
        pc_wren = 1'b1; pc_mux = 2'd2; alu_result = 32'h000003FC;
        tick();
        chk("wrap_pre", 32'(pc), 32'h3FC);
        pc_mux = 2'd0;
        tick();
        chk("wrap_pc", 32'(pc), 32'h000);
        chk1("wrap_mis", pc_misaligned, 1'b0);

        // Branch offset, JALR target with misalignment, reset vector
        pc_mux = 2'd2; alu_result = 32'h00000100;
        tick();
        pc_mux = 2'd1; pc_immediate = 10'h3F8;
        tick();
        chk("imm_pc", 32'(pc), 32'h0F8);
        chk1("imm_mis", pc_misaligned, 1'b0);
        pc_mux = 2'd2; alu_result = 32'h00000123;
        tick();
        chk("jalr_pc", 32'(pc), 32'h120);
        chk1("jalr_mis", pc_misaligned, 1'b1);
        pc_mux = 2'd3;
        tick();
        chk("rstvec_pc", 32'(pc), 32'h000);
        chk1("mis_pulse", pc_misaligned, 1'b0);

        // Slow memory with pc update and extra ir_wren during the wait
        pc_mux = 2'd2; alu_result = 32'h00000040;
        tick();
        pc_wren = 1'b0;
        ir_wren = 1'b1;
        tick();
        ir_wren = 1'b0;
        chk("slow_addr0", 32'(imem_addr), 32'h040);
        pc_wren = 1'b1; pc_mux = 2'd0; ir_wren = 1'b1;
        tick();
        pc_wren = 1'b0; ir_wren = 1'b0;
        chk("slow_pc", 32'(pc), 32'h044);
        for (int i = 0; i < 3; i++) begin
            chk1("slow_req", imem_req, 1'b1);
            chk("slow_addr", 32'(imem_addr), 32'h040);
            chk1("slow_nodone", fetch_done, 1'b0);
            if (i < 2) tick();
        end
        imem_valid = 1'b1; imem_rdata = 32'h00A00113;
        tick();
        imem_valid = 1'b0;
        chk("slow_insn", instruction, 32'h00A00113);
        chk1("slow_done", fetch_done, 1'b1);
        chk("slow_addr_end", 32'(imem_addr), 32'h040);

        // Back-to-back fetch requested in the DONE cycle
        ir_wren = 1'b1;
        tick();
        ir_wren = 1'b0;
        chk1("b2b_done_off", fetch_done, 1'b0);
        chk1("b2b_req", imem_req, 1'b1);
        chk("b2b_addr", 32'(imem_addr), 32'h044);
        imem_valid = 1'b1; imem_rdata = 32'h00100073;
        tick();
        imem_valid = 1'b0;
        chk("b2b_insn", instruction, 32'h00100073);
        tick();
        chk1("b2b_idle_req", imem_req, 1'b0);

        // Reset during an outstanding request, then a late valid
        ir_wren = 1'b1;
        tick();
        ir_wren = 1'b0;
        chk1("abort_req_pre", imem_req, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("abort_req", imem_req, 1'b0);
        imem_valid = 1'b1; imem_rdata = 32'hDEADBEEF;
        tick();
        imem_valid = 1'b0;
        chk("abort_insn", instruction, 32'h00000013);
        chk1("abort_nodone", fetch_done, 1'b0);
        chk1("abort_req2", imem_req, 1'b0);

`ifdef FETCH_TIMEOUT_EN
        // Load a non-NOP instruction so the substitution is observable
        ir_wren = 1'b1;
        tick();
        ir_wren = 1'b0; imem_valid = 1'b1; imem_rdata = 32'h00208033;
        tick();
        imem_valid = 1'b0;
        tick();
        ir_wren = 1'b1;
        tick();
        ir_wren = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk1("to_req", imem_req, 1'b1);
            chk1("to_nofault", fetch_fault, 1'b0);
            tick();
        end
        chk1("to_req_last", imem_req, 1'b1);
        tick();
        chk("to_insn", instruction, 32'h00000013);
        chk1("to_fault", fetch_fault, 1'b1);
        chk1("to_done", fetch_done, 1'b1);
        chk1("to_req_off", imem_req, 1'b0);
        tick();
        chk1("to_sticky", fetch_fault, 1'b1);
        ir_wren = 1'b1;
        tick();
        ir_wren = 1'b0;
        chk1("to_clear", fetch_fault, 1'b0);
        imem_valid = 1'b1; imem_rdata = 32'h00000013;
        tick();
        imem_valid = 1'b0;
        tick();
`else
        // Without the watchdog a silent memory stalls the fetch indefinitely
        ir_wren = 1'b1;
        tick();
        ir_wren = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk1("nowd_req", imem_req, 1'b1);
        chk1("nowd_fault", fetch_fault, 1'b0);
        chk1("nowd_nodone", fetch_done, 1'b0);
        imem_valid = 1'b1; imem_rdata = 32'h00300193;
        tick();
        imem_valid = 1'b0;
        chk("nowd_insn", instruction, 32'h00300193);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
